memory_responder: RTL

//  Target-side end of the switch configuration memory bus. Accepts read/write requests

---
 rtl/memory_pack.sv | 18 +
 rtl/memory_resp_array.sv | 40 ++++
 rtl/memory_responder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/memory_pack.sv
// Shared definitions for the configuration memory bus: FSM state encoding,
// transfer direction codes and default bus widths.
package memory_pack;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } mem_resp_state_e;

    localparam logic MEM_WRITE = 1'b1;
    localparam logic MEM_READ  = 1'b0;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;

endpackage

// File: rtl/memory_resp_array.sv
// Configuration store: synchronous write, synchronous clear of every entry,
// and a registered read port that holds its value between reads.
module memory_resp_array
    import memory_pack::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];
    logic [DATA_W-1:0] rdata_r;

    // Storage update, clear on reset, and read-port register.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem_r[i] <= '0;
            end
            rdata_r <= '0;
        end else begin
            if (we) begin
                mem_r[addr] <= wdata;
            end
            if (re) begin
                rdata_r <= mem_r[addr];
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/memory_responder.sv
// Target end of the switch configuration memory bus with parameterised wait states.
// Optional read-only upper region enabled by defining MEM_RO_REGION_EN.
module memory_responder
    import memory_pack::*;
#(
    parameter int                ADDR_W      = MEM_ADDR_W,
    parameter int                DATA_W      = MEM_DATA_W,
    parameter int                WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] RO_BASE     = 8'hF0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_sel_en,
    input  logic              mem_wr_rd_s,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wr_data,
    output logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_ack,
    output logic              busy,
    output logic              wr_violation
);

    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    mem_resp_state_e   state_r;
    logic [3:0]        cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic              wr_r;
    logic              ack_r;
    logic              busy_r;

    logic              go_s;
    logic              ro_s;
    logic              we_s;
    logic              re_s;
    logic [ADDR_W-1:0] cur_addr_s;
    logic [DATA_W-1:0] cur_data_s;
    logic              cur_wr_s;

    // Select the live inputs in IDLE (zero-wait path) or the latched request otherwise,
    // and decide whether this edge enters ACK.
    always_comb begin
        go_s       = 1'b0;
        cur_addr_s = addr_r;
        cur_data_s = data_r;
        cur_wr_s   = wr_r;
        case (state_r)
            IDLE: begin
                cur_addr_s = mem_addr;
                cur_data_s = mem_wr_data;
                cur_wr_s   = mem_wr_rd_s;
                go_s       = mem_sel_en && (WAIT_STATES == 0);
            end
            WAIT: begin
                go_s = mem_sel_en && (cnt_r == 4'd0);
            end
            default: begin
                go_s = 1'b0;
            end
        endcase
`ifdef MEM_RO_REGION_EN
        ro_s = (cur_addr_s >= RO_BASE);
`else
        ro_s = 1'b0;
`endif
        we_s = go_s && (cur_wr_s == MEM_WRITE) && !ro_s;
        re_s = go_s && (cur_wr_s == MEM_READ);
    end

    // Handshake FSM with wait counter and registered ack/busy.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= '0;
            data_r  <= '0;
            wr_r    <= 1'b0;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (mem_sel_en) begin
                        addr_r <= mem_addr;
                        data_r <= mem_wr_data;
                        wr_r   <= mem_wr_rd_s;
                        busy_r <= 1'b1;
                        if (go_s) begin
                            state_r <= ACK;
                            ack_r   <= 1'b1;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= CNT_LOAD;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                WAIT: begin
                    if (!mem_sel_en) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (go_s) begin
                        state_r <= ACK;
                        ack_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ACK: begin
                    state_r <= DONE;
                end
                DONE: begin
                    if (!mem_sel_en) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_RO_REGION_EN
    logic viol_r;

    // Sticky flag for a write acked into the read-only region.
    always_ff @(posedge clock) begin
        if (reset) begin
            viol_r <= 1'b0;
        end else if (go_s && (cur_wr_s == MEM_WRITE) && ro_s) begin
            viol_r <= 1'b1;
        end else begin
            viol_r <= viol_r;
        end
    end

    assign wr_violation = viol_r;
`else
    assign wr_violation = 1'b0;
`endif

    memory_resp_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .we    (we_s),
        .re    (re_s),
        .addr  (cur_addr_s),
        .wdata (cur_data_s),
        .rdata (mem_rd_data)
    );

    assign mem_ack = ack_r;
    assign busy    = busy_r;

endmodule
